// File: rtl/jpeg_raster2blk.sv
// jpeg_raster2blk: buffers raster strips in a ping-pong line memory and
// replays them as level-shifted 8x8 blocks with block/frame start strobes.
module jpeg_raster2blk #(
    parameter int PIC_WIDTH  = 32,
    parameter int PIC_HEIGHT = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid_i,
    input  logic       pix_sof_i,
    input  logic [7:0] pix_data_i,
    output logic [7:0] pic_data_o,
    output logic       pic_valid_o,
    output logic       pic_blk_go_o,
    output logic       pic_frame_o
);
    localparam int BW  = 8 * PIC_WIDTH;
    localparam int AW  = $clog2(2 * BW);
    localparam int CW  = $clog2(PIC_WIDTH);
    localparam int NB  = PIC_WIDTH / 8;
    localparam int BKW = NB > 1 ? $clog2(NB) : 1;
    localparam int NS  = PIC_HEIGHT / 8;
    localparam int SW  = NS > 1 ? $clog2(NS) : 1;

    typedef enum logic {IDLE, READ} state_t;

    logic [7:0]     mem [2*BW];
    logic [7:0]     mem_q;
    logic [CW-1:0]  col_q, col_e;
    logic [2:0]     row_q, row_e;
    logic           wbank_q;
    logic [SW-1:0]  strip_q;
    logic [1:0]     tag_q;
    logic           sof, col_wrap, wr_done;
    logic [AW-1:0]  wr_addr, rd_addr;
    state_t         state_q;
    logic           rbank_q;
    logic [BKW-1:0] blk_q;
    logic [2:0]     r_q, c_q;
    logic [1:0]     full_q, full_d;
    logic           rd_en, rd_last, nxt_full;
    logic           v1_q, b1_q, f1_q;

    // An SOF pixel behaves as if col/row were already zero, discarding the partial bank.
    always_comb begin
        sof      = pix_valid_i & pix_sof_i;
        col_e    = sof ? '0 : col_q;
        row_e    = sof ? '0 : row_q;
        col_wrap = col_e == CW'(PIC_WIDTH - 1);
        wr_done  = pix_valid_i & col_wrap & (row_e == 3'd7);
        wr_addr  = (wbank_q ? AW'(BW) : '0) + AW'(row_e) * AW'(PIC_WIDTH) + AW'(col_e);
        rd_en    = state_q == READ;
        rd_last  = rd_en & (blk_q == BKW'(NB - 1)) & (r_q == 3'd7) & (c_q == 3'd7);
        rd_addr  = (rbank_q ? AW'(BW) : '0) + AW'(r_q) * AW'(PIC_WIDTH) + AW'({blk_q, c_q});
        full_d   = full_q;
        if (rd_last) full_d[rbank_q] = 1'b0;
        if (wr_done) full_d[wbank_q] = 1'b1;
        nxt_full = full_d[~rbank_q];
    end

    always_ff @(posedge clk) begin
        if (pix_valid_i) mem[wr_addr] <= pix_data_i;
        if (rd_en) mem_q <= mem[rd_addr];
    end

    // Writer; the strip index at fill time decides whether the bank opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            wbank_q <= 1'b0;
            strip_q <= '0;
            tag_q   <= '0;
        end else if (pix_valid_i) begin
            col_q <= col_wrap ? '0 : col_e + CW'(1);
            row_q <= col_wrap ? row_e + 3'd1 : row_e;
            if (wr_done) begin
                wbank_q        <= ~wbank_q;
                tag_q[wbank_q] <= strip_q == '0;
                strip_q        <= strip_q == SW'(NS - 1) ? '0 : strip_q + SW'(1);
            end else if (sof) begin
                strip_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rbank_q      <= 1'b0;
            blk_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            full_q       <= '0;
            v1_q         <= 1'b0;
            b1_q         <= 1'b0;
            f1_q         <= 1'b0;
            pic_data_o   <= '0;
            pic_valid_o  <= 1'b0;
            pic_blk_go_o <= 1'b0;
            pic_frame_o  <= 1'b0;
        end else begin
            full_q       <= full_d;
            v1_q         <= rd_en;
            b1_q         <= rd_en & (r_q == 3'd0) & (c_q == 3'd0);
            f1_q         <= rd_en & (blk_q == '0) & (r_q == 3'd0) & (c_q == 3'd0) & tag_q[rbank_q];
            pic_valid_o  <= v1_q;
            pic_blk_go_o <= b1_q;
            pic_frame_o  <= f1_q;
            pic_data_o   <= v1_q ? {~mem_q[7], mem_q[6:0]} : '0;
            if (state_q == IDLE) begin
                if (full_q[rbank_q]) begin
                    state_q <= READ;
                    blk_q   <= '0;
                    r_q     <= '0;
                    c_q     <= '0;
                end
            end else begin
                c_q <= c_q + 3'd1;
                if (c_q == 3'd7) begin
                    r_q <= r_q + 3'd1;
                    if (r_q == 3'd7) blk_q <= blk_q == BKW'(NB - 1) ? '0 : blk_q + BKW'(1);
                end
                // Counters wrap to zero here, so a waiting bank streams with no gap.
                if (rd_last) begin
                    rbank_q <= ~rbank_q;
                    state_q <= nxt_full ? READ : IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_jpeg_raster2blk.sv
// tb_jpeg_raster2blk: drives raster frames and checks the block stream
// against an expected-sample queue built from whole-image block order.
module tb_jpeg_raster2blk;
    localparam int W = 32;
    localparam int H = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_valid_i = 1'b0;
    logic       pix_sof_i = 1'b0;
    logic [7:0] pix_data_i = 8'd0;
    logic [7:0] pic_data_o;
    logic       pic_valid_o, pic_blk_go_o, pic_frame_o;

    jpeg_raster2blk #(.PIC_WIDTH(W), .PIC_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid_i(pix_valid_i), .pix_sof_i(pix_sof_i), .pix_data_i(pix_data_i),
        .pic_data_o(pic_data_o), .pic_valid_o(pic_valid_o),
        .pic_blk_go_o(pic_blk_go_o), .pic_frame_o(pic_frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] d; logic b; logic f;} exp_t;
    exp_t       q[$];
    exp_t       e;
    int         n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] img [H][W];
    logic [7:0] cap [4096];
    logic [7:0] refc [768];
    int         cap_n, nblk, nfrm, vcnt, vfirst, vlast;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) if (rst_n) begin
        if (pic_valid_o) begin
            if (cap_n < 4096) cap[cap_n] = pic_data_o;
            cap_n++;
            if (vcnt == 0) vfirst = cyc;
            vlast = cyc;
            vcnt++;
            nblk += int'(pic_blk_go_o);
            nfrm += int'(pic_frame_o);
        end
        if (q.size() == 0) chk("idle_valid", 32'(pic_valid_o), 0);
        else if (pic_valid_o) begin
            e = q.pop_front();
            chk("data", 32'(pic_data_o), 32'(e.d));
            chk("blk_go", 32'(pic_blk_go_o), 32'(e.b));
            chk("frame", 32'(pic_frame_o), 32'(e.f));
        end
    end

    task automatic stats();
        cap_n = 0; nblk = 0; nfrm = 0; vcnt = 0; vfirst = 0; vlast = 0;
    endtask

    task automatic fill_img(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                int k;
                k = (r * W + c) % 3;
                img[r][c] = kind == 0 ? 8'((r * W + c) % 256) :
                            kind == 1 ? 8'($urandom) :
                            k == 0 ? 8'h00 : k == 1 ? 8'h80 : 8'hFF;
            end
    endtask

    // Block order: blocks left to right, rows within a block, columns within a row.
    task automatic push_strip(input int s);
        for (int b = 0; b < W / 8; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    q.push_back('{8'(img[s*8+r][b*8+c] - 8'd128), r == 0 && c == 0,
                                  s == 0 && b == 0 && r == 0 && c == 0});
    endtask

    task automatic px(input logic v, input logic s, input logic [7:0] d);
        pix_valid_i = v; pix_sof_i = s; pix_data_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int mode, input bit lat, input int npx);
        for (int i = 0; i < npx; i++) begin
            px(1'b1, i == 0, img[i/W][i%W]);
            if ((i + 1) % (8 * W) == 0) begin
                push_strip(i / (8 * W));
                if (lat) begin
                    int n;
                    pix_valid_i = 1'b0;
                    n = 0;
                    while (n < 10) begin
                        @(negedge clk);
                        if (pic_valid_o) break;
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    chk("latency", 32'(n), 3);
                end
            end
            if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) px(1'b0, 1'b0, 8'd0);
        end
        pix_valid_i = 1'b0;
        pix_sof_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20000 && q.size() > 0; i++) @(posedge clk);
        chk("drain", 32'(q.size()), 0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        int diffs;
        #12;
        chk("rst_out", 32'({pic_data_o, pic_valid_o, pic_blk_go_o, pic_frame_o}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        stats(); fill_img(0);
        send_frame(0, 1'b0, H * W);
        drain();
        chk("ramp_s1b2_r3c5", 32'(cap[413]), 32'h0F5);
        chk("ramp_blk_go", 32'(nblk), 12);
        chk("ramp_frame", 32'(nfrm), 1);
        chk("ramp_count", 32'(vcnt), 768);
        chk("ramp_contig", 32'(vlast - vfirst + 1), 768);
        for (int i = 0; i < 768; i++) refc[i] = cap[i];

        stats();
        send_frame(1, 1'b1, H * W);
        drain();
        diffs = 0;
        for (int i = 0; i < 768; i++) diffs += int'(cap[i] !== refc[i]);
        chk("toggle_same_seq", 32'(diffs), 0);
        chk("toggle_count", 32'(cap_n), 768);

        stats();
        fill_img(1); send_frame(0, 1'b0, H * W);
        fill_img(1); send_frame(0, 1'b0, H * W);
        drain();
        chk("b2b_count", 32'(vcnt), 1536);
        chk("b2b_contig", 32'(vlast - vfirst + 1), 32'(vcnt));
        chk("b2b_frames", 32'(nfrm), 2);

        stats();
        fill_img(1); send_frame(2, 1'b0, 8 * W + 3 * W + 10);
        fill_img(1); send_frame(2, 1'b0, H * W);
        drain();
        chk("abort_count", 32'(vcnt), 1024);
        chk("abort_frames", 32'(nfrm), 2);

        stats(); fill_img(0);
        send_frame(0, 1'b0, 8 * W + 20);
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 32'({pic_data_o, pic_valid_o, pic_blk_go_o, pic_frame_o}), 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        stats(); fill_img(1);
        send_frame(2, 1'b0, H * W);
        drain();
        chk("post_rst_count", 32'(vcnt), 768);
        chk("post_rst_frames", 32'(nfrm), 1);

        stats(); fill_img(2);
        send_frame(0, 1'b0, H * W);
        drain();
        chk("val_00", 32'(cap[0]), 32'h80);
        chk("val_80", 32'(cap[1]), 32'h00);
        chk("val_ff", 32'(cap[2]), 32'h7F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
